// File: rtl/dds_phase2amp.sv
`default_nettype none
// ============================================================================
//  Module      : dds_phase2amp
//  Description : DDS phase-to-amplitude converter. Truncates the accumulator
//                phase and maps it to an offset-binary amplitude through a
//                sine (quarter-wave ROM), triangle, sawtooth or square map.
//                A new waveform is applied only at a phase wrap. 3-stage
//                pipeline with valid strobe and per-period cycle_start.
//                Optional feature macro: DDS_P2A_PHASE_DITHER_EN adds LFSR
//                dither to the discarded phase bits before truncation.
//  Revision    : 1.0 - initial release
// ============================================================================
module dds_phase2amp #(
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 10,
    parameter int AMP_W   = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PHASE_W-1:0] phase_in,
    input  logic               phase_vld,
    input  logic [1:0]         wave_sel,
    output logic [AMP_W-1:0]   amp_out,
    output logic               amp_vld,
    output logic               cycle_start
);

    localparam int c_LOW_W = PHASE_W - ADDR_W;
    localparam int c_Q_W   = ADDR_W - 2;
    localparam int c_N     = 1 << c_Q_W;

    localparam logic [1:0] c_WAVE_SINE = 2'd0;
    localparam logic [1:0] c_WAVE_TRI  = 2'd1;
    localparam logic [1:0] c_WAVE_SAW  = 2'd2;
    localparam logic [1:0] c_WAVE_SQR  = 2'd3;

    localparam logic [AMP_W-1:0] c_MID    = {1'b1, {(AMP_W-1){1'b0}}};
    localparam logic [AMP_W-1:0] c_MID_M1 = {1'b0, {(AMP_W-1){1'b1}}};

    // Quarter-wave sample taken at the centre of each index bin.
    function automatic logic [AMP_W-2:0] f_rom_entry(input int idx);
        real l_ang;
        real l_val;
        l_ang = 3.14159265358979323846 / 2.0 * (real'(idx) + 0.5) / real'(c_N);
        l_val = real'((1 << (AMP_W-1)) - 1) * $sin(l_ang);
        return (AMP_W-1)'($rtoi(l_val + 0.5));
    endfunction

    logic [AMP_W-2:0] w_rom_tab [c_N];

    for (genvar gi = 0; gi < c_N; gi++) begin : g_rom
        assign w_rom_tab[gi] = f_rom_entry(gi);
    end

    // ------------------------------------------------------------------
    // Phase conditioning (optional dither) and truncation
    // ------------------------------------------------------------------
    logic [PHASE_W-1:0] w_phase;

`ifdef DDS_P2A_PHASE_DITHER_EN
    logic [15:0]        r_lfsr;
    logic               w_lfsr_fb;
    logic [PHASE_W-1:0] w_dith;

    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // Dither LFSR steps once per accepted sample so bubbles leave it frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 16'hACE1;
        end else if (phase_vld) begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    if (c_LOW_W >= 16) begin : g_dith_wide
        assign w_dith = PHASE_W'(r_lfsr);
    end else begin : g_dith_narrow
        assign w_dith = PHASE_W'(r_lfsr[c_LOW_W-1:0]);
    end

    // Carry out of the discarded bits ripples into p; the top wraps naturally.
    assign w_phase = phase_in + w_dith;
`else
    assign w_phase = phase_in;
`endif

    // Bits below the truncation point never reach the amplitude map.
    logic w_unused_low;
    assign w_unused_low = ^w_phase[c_LOW_W-1:0];

    logic [ADDR_W-1:0] w_p;
    logic              w_wrap;
    logic [1:0]        w_mode;

    logic              r_started;
    logic [ADDR_W-1:0] r_p_prev;
    logic [1:0]        r_mode;

    assign w_p    = w_phase[PHASE_W-1 -: ADDR_W];
    assign w_wrap = ~r_started | (w_p < r_p_prev);
    assign w_mode = w_wrap ? wave_sel : r_mode;

    // ------------------------------------------------------------------
    // Stage 1: wrap tracking, mode latch and truncated phase register
    // ------------------------------------------------------------------
    logic              r1_vld;
    logic              r1_wrap;
    logic [1:0]        r1_mode;
    logic [ADDR_W-1:0] r1_p;

    // Control state only advances on valid samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_vld    <= 1'b0;
            r1_wrap   <= 1'b0;
            r1_mode   <= c_WAVE_SINE;
            r1_p      <= '0;
            r_started <= 1'b0;
            r_p_prev  <= '0;
            r_mode    <= c_WAVE_SINE;
        end else begin
            r1_vld <= phase_vld;
            if (phase_vld) begin
                r1_wrap   <= w_wrap;
                r1_mode   <= w_mode;
                r1_p      <= w_p;
                r_started <= 1'b1;
                r_p_prev  <= w_p;
                r_mode    <= w_mode;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: ROM read and non-sine precompute
    // ------------------------------------------------------------------
    logic [c_Q_W-1:0] w_q;
    logic [c_Q_W-1:0] w_rom_addr;
    logic [AMP_W-1:0] w_tri_up;

    assign w_q        = r1_p[c_Q_W-1:0];
    // Odd quadrants read the quarter wave backwards: N-1-q == ~q.
    assign w_rom_addr = r1_p[ADDR_W-2] ? ~w_q : w_q;
    assign w_tri_up   = {r1_p[ADDR_W-2:0], 1'b0};

    logic             r2_vld;
    logic             r2_wrap;
    logic [1:0]       r2_mode;
    logic             r2_neg;
    logic [AMP_W-2:0] r2_rom;
    logic [AMP_W-1:0] r2_tri;
    logic [AMP_W-1:0] r2_saw;
    logic [AMP_W-1:0] r2_sqr;

    // Pipeline control for stage 2 (flushed by reset).
    always_ff @(posedge clk) begin
        if (rst) begin
            r2_vld  <= 1'b0;
            r2_wrap <= 1'b0;
            r2_mode <= c_WAVE_SINE;
        end else begin
            r2_vld <= r1_vld;
            if (r1_vld) begin
                r2_wrap <= r1_wrap;
                r2_mode <= r1_mode;
            end
        end
    end

    // Datapath registers left without reset so the ROM can map to block memory.
    always_ff @(posedge clk) begin
        if (r1_vld) begin
            r2_rom <= w_rom_tab[w_rom_addr];
            r2_neg <= r1_p[ADDR_W-1];
            r2_tri <= r1_p[ADDR_W-1] ? ~w_tri_up : w_tri_up;
            r2_saw <= r1_p;
            r2_sqr <= {AMP_W{~r1_p[ADDR_W-1]}};
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: sine fold, waveform select, output register
    // ------------------------------------------------------------------
    logic [AMP_W-1:0] w_rom_ext;
    logic [AMP_W-1:0] w_sine;
    logic [AMP_W-1:0] w_amp_nxt;

    assign w_rom_ext = {1'b0, r2_rom};
    // Lower half-wave mirrors around midscale minus one to stay in range.
    assign w_sine    = r2_neg ? (c_MID_M1 - w_rom_ext) : (c_MID + w_rom_ext);

    // Select the map chosen for this sample's period.
    always_comb begin
        w_amp_nxt = w_sine;
        case (r2_mode)
            c_WAVE_SINE: w_amp_nxt = w_sine;
            c_WAVE_TRI:  w_amp_nxt = r2_tri;
            c_WAVE_SAW:  w_amp_nxt = r2_saw;
            c_WAVE_SQR:  w_amp_nxt = r2_sqr;
            default:     w_amp_nxt = w_sine;
        endcase
    end

    // Output holds its value across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            amp_out     <= c_MID;
            amp_vld     <= 1'b0;
            cycle_start <= 1'b0;
        end else begin
            amp_vld     <= r2_vld;
            cycle_start <= r2_vld & r2_wrap;
            if (r2_vld) begin
                amp_out <= w_amp_nxt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dds_phase2amp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dds_phase2amp
//  Description : Directed self-checking bench for dds_phase2amp (dither off).
//                Inputs are driven per cycle; outputs are logged on the
//                falling edge and compared against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dds_phase2amp;

    localparam int c_DEPTH = 8192;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] phase_in = '0;
    logic        phase_vld = 1'b0;
    logic [1:0]  wave_sel = 2'd0;
    logic [9:0]  amp_out;
    logic        amp_vld;
    logic        cycle_start;

    dds_phase2amp #(
        .PHASE_W (32),
        .ADDR_W  (10),
        .AMP_W   (10)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .phase_in    (phase_in),
        .phase_vld   (phase_vld),
        .wave_sel    (wave_sel),
        .amp_out     (amp_out),
        .amp_vld     (amp_vld),
        .cycle_start (cycle_start)
    );

    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    logic [9:0] h_amp [c_DEPTH];
    logic       h_vld [c_DEPTH];
    logic       h_cs  [c_DEPTH];

    always @(negedge clk) begin
        if (cyc_n < c_DEPTH) begin
            h_amp[cyc_n] = amp_out;
            h_vld[cyc_n] = amp_vld;
            h_cs[cyc_n]  = cycle_start;
        end
    end

    bit         e_on  [c_DEPTH];
    logic [9:0] e_amp [c_DEPTH];
    logic       e_vld [c_DEPTH];
    logic       e_cs  [c_DEPTH];
    string      e_tag [c_DEPTH];

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs; k is the cycle index they occupy.
    task automatic drv(input logic r, input logic v, input int p, input logic [1:0] s, output int k);
        k         = cyc_n;
        rst       = r;
        phase_vld = v;
        phase_in  = 32'(p) << 22;
        wave_sel  = s;
        @(posedge clk);
        #1;
    endtask

    task automatic want(input int idx, input string tag, input logic v, input int a, input logic c);
        e_on[idx]  = 1'b1;
        e_vld[idx] = v;
        e_amp[idx] = 10'(a);
        e_cs[idx]  = c;
        e_tag[idx] = tag;
    endtask

    int sp [4] = '{0, 256, 512, 768};
    int sa [4] = '{514, 1023, 509, 0};
    int tp [6] = '{0, 100, 511, 512, 700, 1023};
    int ta [6] = '{0, 200, 1022, 1023, 647, 1};
    int bv [7] = '{1, 0, 0, 1, 1, 0, 1};
    int bp [7] = '{900, 5, 5, 950, 1000, 5, 10};
    int ba [7] = '{900, 900, 900, 950, 1000, 1000, 10};
    int bc [7] = '{1, 0, 0, 0, 0, 0, 1};

    initial begin
        int k;
        int k0;

        // Reset held two cycles with valid inputs present
        drv(1'b1, 1'b1, 7, 2'd2, k);
        drv(1'b1, 1'b1, 9, 2'd2, k);
        want(1, "rst_hold", 1'b0, 512, 1'b0);
        want(2, "rst_hold", 1'b0, 512, 1'b0);
        want(3, "rst_flush", 1'b0, 512, 1'b0);
        want(4, "rst_flush", 1'b0, 512, 1'b0);

        // Sawtooth sweep, two full periods; first sample also the post-reset wrap
        for (int i = 0; i < 2048; i++) begin
            drv(1'b0, 1'b1, i % 1024, 2'd2, k);
            want(k + 3, "saw", 1'b1, i % 1024, (i % 1024) == 0);
        end

        // Square requested mid-period: takes effect only at the next wrap
        for (int i = 0; i < 1024; i++) begin
            drv(1'b0, 1'b1, i, (i < 100) ? 2'd2 : 2'd3, k);
            want(k + 3, "defer_saw", 1'b1, i, i == 0);
        end
        for (int i = 0; i < 1024; i++) begin
            drv(1'b0, 1'b1, i, 2'd3, k);
            want(k + 3, "defer_sqr", 1'b1, (i < 512) ? 1023 : 0, i == 0);
        end

        // Sine quadrants
        for (int j = 0; j < 4; j++) begin
            drv(1'b0, 1'b1, sp[j], 2'd0, k);
            want(k + 3, "sine", 1'b1, sa[j], j == 0);
        end

        // Triangle points
        for (int j = 0; j < 6; j++) begin
            drv(1'b0, 1'b1, tp[j], 2'd1, k);
            want(k + 3, "tri", 1'b1, ta[j], j == 0);
        end

        // Bubbles, with a wrap across a bubble at the end
        for (int j = 0; j < 7; j++) begin
            drv(1'b0, bv[j][0], bp[j], 2'd2, k);
            want(k + 3, "bubble", bv[j][0], ba[j], bc[j][0]);
        end

        // Reset mid-stream flushes in-flight samples; next sample is a wrap
        drv(1'b0, 1'b1, 200, 2'd2, k0);
        drv(1'b0, 1'b1, 300, 2'd2, k);
        drv(1'b1, 1'b1, 400, 2'd2, k);
        want(k0 + 3, "mid_rst", 1'b0, 512, 1'b0);
        want(k0 + 4, "mid_rst", 1'b0, 512, 1'b0);
        want(k0 + 5, "mid_rst", 1'b0, 512, 1'b0);
        drv(1'b0, 1'b1, 500, 2'd0, k);
        want(k + 3, "post_rst", 1'b1, 548, 1'b1);

        for (int j = 0; j < 5; j++) begin
            drv(1'b0, 1'b0, 0, 2'd0, k);
        end

        for (int idx = 0; idx < c_DEPTH; idx++) begin
            if (e_on[idx] && idx < cyc_n) begin
                check_val($sformatf("%s[%0d].vld", e_tag[idx], idx), 32'(h_vld[idx]), 32'(e_vld[idx]));
                check_val($sformatf("%s[%0d].amp", e_tag[idx], idx), 32'(h_amp[idx]), 32'(e_amp[idx]));
                check_val($sformatf("%s[%0d].cs", e_tag[idx], idx), 32'(h_cs[idx]), 32'(e_cs[idx]));
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dds_phase2amp.md
# dds_phase2amp

Phase-to-amplitude converter for the DDS chain, sitting directly downstream of the phase accumulator. It truncates the accumulated phase word and maps it to an unsigned offset-binary amplitude. The map is selectable as sine (quarter-wave ROM with symmetry folding), triangle, sawtooth or square. Mode changes are glitch-free: a new mode is applied only at a phase wrap. The block is a 3-stage pipeline with a valid strobe and a per-period `cycle_start` marker for downstream DAC/trigger logic.

## Interface
- `PHASE_W`, 32: accumulator phase word width.
- `ADDR_W`, 10: phase bits kept after truncation (top bits of `phase_in`); ≥ 4.
- `AMP_W`, 10: amplitude width; must equal `ADDR_W`.

- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `phase_in`  in  PHASE_W  accumulator phase word.
- `phase_vld`  in  1  `phase_in` valid this cycle.
- `wave_sel`  in  2  requested waveform: 0 sine, 1 triangle, 2 sawtooth, 3 square.
- `amp_out`  out  AMP_W  amplitude, offset binary, midscale = 2^(AMP_W-1).
- `amp_vld`  out  1  `amp_out` updated this cycle.
- `cycle_start`  out  1  pulse aligned with `amp_vld`; marks the first sample of a new period.

## Operation
- Truncated phase p = `phase_in[PHASE_W-1 -: ADDR_W]`. Quadrant qd = p[top 2 bits]. Index q = p[ADDR_W-3:0]. N = 2^(ADDR_W-2).
- ROM: N entries. rom[i] = round((2^(AMP_W-1)-1)·sin(π/2·(i+0.5)/N)). Contents are generated at elaboration. Read is synchronous.
- Sine: qd0 → M+rom[q]; qd1 → M+rom[N-1-q]; qd2 → M-1-rom[q]; qd3 → M-1-rom[N-1-q], where M = 2^(AMP_W-1).
- Triangle: MSB=0 → p[ADDR_W-2:0]<<1; MSB=1 → (2^AMP_W-1) − (p[ADDR_W-2:0]<<1).
- Sawtooth: p. Square: MSB=0 → 2^AMP_W-1; MSB=1 → 0.
- Wrap detection, on valid samples only: wrap = (p < p_prev), where p_prev is p of the previous valid sample. The first valid sample after reset counts as a wrap.
- Mode register: `wave_sel` is sampled on every valid sample. It becomes the active mode only on a wrap sample, and that sample already uses the new mode. Non-wrap samples use the held active mode.
- `cycle_start` = wrap flag of the sample, pipelined alongside it.
- Invalid cycles create bubbles. They do not update p_prev, the mode or the LFSR. `amp_out` holds its last value.

## Timing
- Latency: 3 cycles from `phase_vld` to `amp_vld`. Stage 1 registers p, qd, wrap and mode. Stage 2 performs the ROM read and the triangle/saw/square precompute. Stage 3 performs the fold/select and output register.
- Throughput: one sample per clock. There is no backpressure.
- Reset values: `amp_out` = 2^(AMP_W-1), `amp_vld` = 0, `cycle_start` = 0, active mode = sine, p_prev = 0, started flag cleared.
- Reset mid-stream flushes all in-flight samples. `amp_vld` is 0 in the cycle after `rst` is sampled high. The next valid sample is treated as the first (wrap = 1).
- Equal consecutive p (K below truncation LSB) is not a wrap.
- p wrapping by more than one step (large K) is still detected by p < p_prev.

## Configuration
- `DDS_P2A_PHASE_DITHER_EN`, when defined:
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1, reloaded on `rst`) advances once per valid sample.
  - Its value, zero-extended or truncated to PHASE_W−ADDR_W bits, is added to the discarded low phase bits before truncation. The carry propagates into p, with wrap-around modulo 2^PHASE_W.
  - Wrap detection uses the dithered p.
- Undefined: plain truncation with no LFSR logic. The test plan runs with the macro undefined unless stated.

## Test plan
- Reset: hold `rst` 2 cycles with `phase_vld`=1 → `amp_out`=512, `amp_vld`=0, `cycle_start`=0 throughout. The first `amp_vld` comes 3 cycles after `rst` falls, with `cycle_start`=1.
- Sine quadrants: `wave_sel`=0, back-to-back valid `phase_in` = {0, 256, 512, 768}<<22 → `amp_out` = 514, 1023, 509, 0 on 4 consecutive cycles, starting 3 cycles after the first input. `cycle_start`=1 only on the first.
- Sawtooth sweep: `wave_sel`=2, phase += 2^22 per cycle for 2048 cycles → `amp_out` ramps 0..1023 twice. `cycle_start` pulses exactly when `amp_out`=0.
- Deferred mode change: sawtooth running, switch `wave_sel` to 3 at p=100 → samples p=100..1023 stay sawtooth. The p=0 sample outputs 1023 with `cycle_start`=1. p=512 outputs 0.
- Bubbles: `phase_vld` pattern 1,0,0,1,1,0,1 → `amp_vld` shows the same pattern 3 cycles later, and `amp_out` holds during the 0s. A wrap across a bubble is still flagged.
- Dither (macro defined): K = 2^21 (half LSB), 4096 samples, sawtooth → every `amp_out` step is 0 or 1. The mean increment is 0.5 ± 0.02. `amp_out` never decreases except at `cycle_start`.
